mux_arb_nto1: RTL and testbench
===============================

Name: mux_arb_nto1

Overview:
Parametrised successor to the 1-bit 2:1 mux: N input channels of WIDTH bits, each with a valid/ready handshake, merged onto one registered output channel. Two modes are supported:
- Fixed-select: the `sel` port chooses the source.
- Round-robin: an internal arbiter chooses the source fairly.

The block sits between pipeline producers (e.g. writeback sources, forwarding paths) and a single consumer stage. It provides one cycle of latency and full throughput.

Parameters:
- WIDTH, 32, data bits per channel.
- N, 4, number of input channels (N >= 2; need not be a power of 2).
- SEL_W, $clog2(N), localparam, width of select/source fields (not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed-select via sel; 1 = round-robin.
- sel  input  SEL_W  source index used in fixed mode; ignored in round-robin mode.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async assert, sync release is the system's job): out_valid=0, out_data=0, out_src=0, rr_ptr=0.
- Transfer semantics:
  - Input transfer on channel i: in_valid[i] & in_ready[i] at a rising edge.
  - Output transfer: out_valid & out_ready.
- Output register load condition: load = ~out_valid | out_ready.
- Grant, combinational, at most one-hot:
  - Fixed mode: g = sel, valid only if sel < N and in_valid[sel]. sel >= N means no grant.
  - RR mode: g = first i with in_valid[i], searching rr_ptr, rr_ptr+1, … wrapping modulo N.
- in_ready[i] = load & grant_hot[i].
  - All other channels see in_ready=0.
  - in_ready may depend on in_valid of other channels and on out_ready.
  - in_valid must not depend on in_ready (producer rule).
- Edge with load=1:
  - If there is a grant: out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - Otherwise: out_valid <= 0; out_data and out_src hold their last value.
- Edge with load=0 (stall): out_data, out_src and out_valid hold, and stay stable until accepted.
- Latency and throughput: input accepted at edge k appears at out_* after edge k; back-to-back acceptance every cycle while out_ready=1.
- rr_ptr:
  - Updates only on an accepted input transfer in RR mode: rr_ptr <= (g == N-1) ? 0 : g+1.
  - Unchanged in fixed mode.
- Mode or sel changes:
  - Sampled combinationally each cycle.
  - An already-registered output is unaffected.
  - A change never corrupts a stalled output.
- Simultaneous events:
  - Output accept and new input accept in the same cycle is a legal replace; no bubble.
  - out_ready=1 with no grant drains to out_valid=0.
- Reset mid-operation: the pending output is discarded (out_valid=0 immediately) and rr_ptr returns to 0.
- Non-power-of-2 N: pointer wrap is at N, never 2^SEL_W; indices >= N are never granted.

Decomposition:
- Shared include file (`mux_arb_defs.vh`) holds the mode constants: MODE_FIXED=1'b0, MODE_RR=1'b1.
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N], ptr[SEL_W].
  - Outputs grant_hot[N], grant_idx[SEL_W], any.
  - Purely combinational rotate-priority search.
- The top level owns the pointer register, the output register and the fixed/RR grant mux.

Test Plan:
- Fixed mode, N=4, WIDTH=32, sel=2, in_data[2]=0xDEADBEEF, in_valid=4'b0100, out_ready=1:
  - in_ready=4'b0100.
  - Next cycle out_data=0xDEADBEEF, out_src=2, out_valid=1.
- Backpressure: hold out_ready=0 for 3 cycles after a load while in_data changes:
  - out_data, out_src and out_valid are stable throughout.
  - in_ready=0.
  - Raise out_ready: the new word loads next edge with no bubble.
- RR fairness: mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles:
  - out_src sequence 0,1,2,3,0,1,2,3.
  - Then in_valid=4'b1010 gives 1,3,1,3.
- Out-of-range and idle: N=3, fixed mode, sel=3, in_valid=3'b111:
  - in_ready=0; out_valid drops to 0 after the pending word is accepted.
  - rr_ptr unchanged, verified by switching to RR and getting src=0 first.
- Reset mid-stall: out_valid=1 with out_ready=0, then assert rst_n=0 asynchronously between edges:
  - out_valid, out_data and out_src become 0 immediately.
  - After release, RR grants channel 0 first.
- Mode switch: RR with rr_ptr=2, switch to fixed sel=0 for 2 transfers, then back to RR with all valid:
  - The next RR grant is 2 (pointer untouched in fixed mode).

Source files
------------

// File: rtl/mux_arb_nto1_pkg.sv
// ============================================================================
// mux_arb_nto1_pkg : default sizes and index helpers for the N:1 arbiter mux
// Revision: 1.0
// ============================================================================
`default_nettype none

package mux_arb_nto1_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 4;

    // Successor of idx in a ring of n entries; wraps at n, not at a power of 2.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_arb_defs.vh
// ============================================================================
// mux_arb_defs.vh : mode encodings shared by the mux_arb_nto1 family
// Revision: 1.0
// ============================================================================
localparam logic MODE_FIXED = 1'b0;
localparam logic MODE_RR    = 1'b1;

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational rotate-priority search starting at ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_arb_nto1_pkg::*;
#(
    parameter  int N     = DEF_N,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant_hot,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any
);

    logic [SEL_W-1:0] w_idx;

    always_comb begin
        grant_hot = '0;
        grant_idx = '0;
        any       = 1'b0;
        // An out-of-range pointer is treated as 0 so indices >= N are never probed.
        w_idx     = (int'(ptr) < N) ? ptr : '0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[w_idx]) begin
                any              = 1'b1;
                grant_hot[w_idx] = 1'b1;
                grant_idx        = w_idx;
            end
            w_idx = SEL_W'(wrap_inc(int'(w_idx), N));
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_arb_nto1.sv
// ============================================================================
// mux_arb_nto1 : N-channel valid/ready merge onto one registered output,
//                fixed-select or round-robin source choice
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_arb_nto1
    import mux_arb_nto1_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N     = DEF_N,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     out_src,
    input  logic                 out_ready
);

    `include "mux_arb_defs.vh"

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]     w_rr_hot;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_rr_any;

    logic [N-1:0]     w_fix_hot;
    logic [N-1:0]     w_grant_hot;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_grant_any;
    logic [WIDTH-1:0] w_grant_data;
    logic             w_load;

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant_hot (w_rr_hot),
        .grant_idx (w_rr_idx),
        .any       (w_rr_any)
    );

    // A sel value >= N matches no channel, so it yields no grant.
    always_comb begin
        w_fix_hot = '0;
        for (int i = 0; i < N; i++) begin
            w_fix_hot[i] = (sel == SEL_W'(i)) && in_valid[i];
        end
    end

    always_comb begin
        w_grant_hot = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        case (mode)
            MODE_FIXED: begin
                w_grant_hot = w_fix_hot;
                w_grant_idx = sel;
                w_grant_any = |w_fix_hot;
            end
            MODE_RR: begin
                w_grant_hot = w_rr_hot;
                w_grant_idx = w_rr_idx;
                w_grant_any = w_rr_any;
            end
        endcase
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_hot[i]) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_load   = !out_valid_q || out_ready;
    assign in_ready = {N{w_load}} & w_grant_hot;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_load) begin
            if (w_grant_any) begin
                out_data_d  = w_grant_data;
                out_src_d   = w_grant_idx;
                out_valid_d = 1'b1;
                if (mode == MODE_RR) begin
                    rr_ptr_d = SEL_W'(wrap_inc(int'(w_grant_idx), N));
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_nto1.sv
// ============================================================================
// tb_mux_arb_nto1 : directed + randomized bench for mux_arb_nto1 (N=4 and N=3)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_arb_nto1;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         mode;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic [1:0]   out_src;
    logic         out_ready;

    logic         d3_mode;
    logic [1:0]   d3_sel;
    logic [95:0]  d3_in_data;
    logic [2:0]   d3_in_valid;
    logic [2:0]   d3_in_ready;
    logic [31:0]  d3_out_data;
    logic         d3_out_valid;
    logic [1:0]   d3_out_src;
    logic         d3_out_ready;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state for the N=4 instance.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;

    always #5 clk = ~clk;

    mux_arb_nto1 #(.WIDTH(32), .N(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    mux_arb_nto1 #(.WIDTH(32), .N(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (d3_mode),
        .sel       (d3_sel),
        .in_data   (d3_in_data),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_src   (d3_out_src),
        .out_ready (d3_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant from the rules: fixed picks sel if in range and valid; RR scans from ptr mod n.
    function automatic int model_grant(input bit md, input int s, input logic [3:0] v,
                                       input int ptr, input int n);
        if (!md) return (s < n && v[s]) ? s : -1;
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = 0;
    endtask

    // One clock of the N=4 instance; called just after a rising edge with inputs set.
    task automatic cycle(input string tag);
        int         g;
        bit         ld;
        logic [3:0] er;
        #1;
        g  = model_grant(mode, int'(sel), in_valid, m_ptr, 4);
        ld = !m_valid || out_ready;
        er = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*32 +: 32];
                m_src   = g;
                if (mode) m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_data"},  out_data, m_data);
        chk({tag, ".out_src"},   32'(out_src), 32'(m_src));
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
    endtask

    task automatic d3_step(input string tag, input logic [2:0] er, input bit ev, input int es);
        #1;
        chk({tag, ".in_ready"}, 32'(d3_in_ready), 32'(er));
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(d3_out_valid), 32'(ev));
        if (ev) begin
            chk({tag, ".out_src"},  32'(d3_out_src), 32'(es));
            chk({tag, ".out_data"}, d3_out_data, 32'h3300_0000 + 32'(es));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        mode         = 1'b0;
        sel          = '0;
        in_data      = '0;
        in_valid     = '0;
        out_ready    = 1'b0;
        d3_mode      = 1'b0;
        d3_sel       = '0;
        d3_in_valid  = '0;
        d3_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) d3_in_data[i*32 +: 32] = 32'h3300_0000 + 32'(i);
        model_reset();

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_data",  out_data, 32'd0);
        chk("reset.out_src",   32'(out_src), 32'd0);
        chk("reset.d3_valid",  32'(d3_out_valid), 32'd0);
        rst_n = 1'b1;

        // Fixed select of channel 2.
        rand_data();
        in_data[64 +: 32] = 32'hDEAD_BEEF;
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        cycle("fixed");
        chk("fixed.data_const", out_data, 32'hDEAD_BEEF);
        chk("fixed.src_const",  32'(out_src), 32'd2);

        // Backpressure: output must hold while the source keeps changing.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_data();
            cycle("stall");
            chk("stall.data_const", out_data, 32'hDEAD_BEEF);
        end
        out_ready = 1'b1;
        rand_data();
        in_data[64 +: 32] = 32'h1234_5678;
        cycle("unstall");
        chk("unstall.data_const", out_data, 32'h1234_5678);

        // Round-robin fairness with all requesters, then alternating requesters.
        mode = 1'b1; in_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            rand_data();
            cycle("rr_all");
            chk("rr_all.seq", 32'(out_src), 32'(c % 4));
        end
        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            cycle("rr_1010");
            chk("rr_1010.seq", 32'(out_src), (c % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 300; c++) begin
            rand_data();
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("random");
        end

        // Pointer parked at 2 must survive fixed-mode transfers.
        out_ready = 1'b1; mode = 1'b1; in_valid = 4'b0010;
        rand_data();
        cycle("msw_rr");
        chk("msw_rr.src", 32'(out_src), 32'd1);
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            rand_data();
            cycle("msw_fixed");
        end
        mode = 1'b1; in_valid = 4'b1111;
        rand_data();
        cycle("msw_back");
        chk("msw_back.src", 32'(out_src), 32'd2);

        // Asynchronous reset while a word is stalled.
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
        rand_data();
        cycle("rst_load");
        out_ready = 1'b0;
        cycle("rst_stall");
        chk("rst_stall.valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid.out_data",  out_data, 32'd0);
        chk("rst_mid.out_src",   32'(out_src), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        rand_data();
        cycle("rst_after");
        chk("rst_after.src", 32'(out_src), 32'd0);

        // N=3: out-of-range sel, pointer preserved across fixed mode, wrap at 3.
        in_valid = 4'b0000;
        d3_mode = 1'b1; d3_in_valid = 3'b001; d3_out_ready = 1'b1;
        d3_step("n3_rr0", 3'b001, 1'b1, 0);
        d3_mode = 1'b0; d3_sel = 2'd0;
        d3_step("n3_fix0", 3'b001, 1'b1, 0);
        d3_sel = 2'd3; d3_in_valid = 3'b111; d3_out_ready = 1'b0;
        d3_step("n3_oor_stall", 3'b000, 1'b1, 0);
        d3_out_ready = 1'b1;
        d3_step("n3_oor_drain", 3'b000, 1'b0, 0);
        d3_mode = 1'b1;
        d3_step("n3_rr_a", 3'b010, 1'b1, 1);
        d3_step("n3_rr_b", 3'b100, 1'b1, 2);
        d3_step("n3_rr_wrap", 3'b001, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
